// File: rtl/l2_port_arbiter_if.sv
// Bus bundle between the L1 caches, the arbiter and the L2 port.
// The slave modport is the arbiter; master is whoever drives it.
interface l2_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic              busy;

  modport master (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_wdata,
    output l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  l2_read, l2_write, l2_addr, l2_wdata,
    input  busy
  );

  modport slave (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output l2_read, l2_write, l2_addr, l2_wdata,
    output busy
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Shares one L2 line port between L1 I and D caches.
// D wins by default; a streak counter bounds I starvation.
module l2_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int MAX_DSTREAK = 4
) (
  input logic               clk,
  input logic               rst_n,
  l2_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    GAP
  } state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     streak, streak_nx;
  logic              op_wr, op_wr_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [LINE_W-1:0] wdata_q, wdata_nx;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;

  logic d_req, g_force, g_d, g_i;
  logic serve, i_done, d_done;

  assign d_req   = bus.d_read | bus.d_write;
  assign g_force = bus.i_read && (streak == SMAX);
  assign g_d     = d_req && !g_force;
  assign g_i     = bus.i_read && !g_d;

  assign serve  = (state == SERVE_I) || (state == SERVE_D);
  assign i_done = (state == SERVE_I) && bus.l2_resp;
  assign d_done = (state == SERVE_D) && bus.l2_resp;

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    op_wr_nx  = op_wr;
    addr_nx   = addr_q;
    wdata_nx  = wdata_q;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          g_i: begin
            state_nx  = SERVE_I;
            op_wr_nx  = 1'b0;
            addr_nx   = bus.i_addr;
            wdata_nx  = '0;
            streak_nx = '0;
          end
          g_d: begin
            state_nx = SERVE_D;
            // both strobes high is illegal; treated as a write
            op_wr_nx = bus.d_write;
            addr_nx  = bus.d_addr;
            wdata_nx = bus.d_wdata;
            if (!bus.i_read)
              streak_nx = '0;
            else if (streak != SMAX)
              streak_nx = streak + SW'(1);
          end
          default: ;
        endcase
      end
      SERVE_I, SERVE_D: begin
        if (bus.l2_resp)
          state_nx = GAP;
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state   <= state_nx;
      streak  <= streak_nx;
      op_wr   <= op_wr_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      if (i_done)
        i_rdata_q <= bus.l2_rdata;
      if (d_done)
        d_rdata_q <= bus.l2_rdata;
    end
  end

  // downstream sees only latched values, never live requester inputs
  assign bus.l2_read  = serve & ~op_wr;
  assign bus.l2_write = serve & op_wr;
  assign bus.l2_addr  = serve ? addr_q : '0;
  assign bus.l2_wdata = serve ? wdata_q : '0;

  assign bus.i_resp  = i_done;
  assign bus.d_resp  = d_done;
  assign bus.i_rdata = i_done ? bus.l2_rdata : i_rdata_q;
  assign bus.d_rdata = d_done ? bus.l2_rdata : d_rdata_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed and random checks of l2_port_arbiter against a
// transaction-level model of the grant/serve/gap rules.
module tb_l2_port_arbiter;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  l2_port_arbiter #(
    .ADDR_W(AW), .LINE_W(LW), .MAX_DSTREAK(MAXD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model: who owns the port (0 none, 1 I, 2 D) and the
  // cooldown cycles left before the next arbitration
  int          m_cur, m_cool, m_streak;
  bit          m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wd, m_li, m_ld;
  bit          e_iresp, e_dresp;

  task automatic chk(string name, logic [LW-1:0] got,
                     logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++)
      v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_cool = 0; m_streak = 0;
    m_wr = 0; m_addr = '0; m_wd = '0;
    m_li = '0; m_ld = '0;
    e_iresp = 0; e_dresp = 0;
  endtask

  task automatic model_update();
    bit dreq;
    dreq = bus.d_read | bus.d_write;
    if (m_cur != 0) begin
      if (bus.l2_resp) begin
        if (m_cur == 1) m_li = bus.l2_rdata;
        else            m_ld = bus.l2_rdata;
        m_cur = 0;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (bus.i_read && m_streak == MAXD) begin
      m_cur = 1; m_wr = 0; m_addr = bus.i_addr; m_wd = '0;
      m_streak = 0;
    end else if (dreq) begin
      m_cur = 2; m_wr = bus.d_write;
      m_addr = bus.d_addr; m_wd = bus.d_wdata;
      if (!bus.i_read) m_streak = 0;
      else if (m_streak < MAXD) m_streak++;
    end else if (bus.i_read) begin
      m_cur = 1; m_wr = 0; m_addr = bus.i_addr; m_wd = '0;
      m_streak = 0;
    end
  endtask

  task automatic compare_all();
    bit srv;
    srv = (m_cur != 0);
    e_iresp = (m_cur == 1) && bus.l2_resp;
    e_dresp = (m_cur == 2) && bus.l2_resp;
    chk("busy", bus.busy, srv || m_cool > 0);
    chk("l2_read", bus.l2_read, srv && !m_wr);
    chk("l2_write", bus.l2_write, srv && m_wr);
    chk("l2_addr", bus.l2_addr, srv ? m_addr : '0);
    chk("l2_wdata", bus.l2_wdata, srv ? m_wd : '0);
    chk("i_resp", bus.i_resp, e_iresp);
    chk("d_resp", bus.d_resp, e_dresp);
    chk("i_rdata", bus.i_rdata, e_iresp ? bus.l2_rdata : m_li);
    chk("d_rdata", bus.d_rdata, e_dresp ? bus.l2_rdata : m_ld);
  endtask

  task automatic step();
    #2;
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_in();
    bus.i_read = 0; bus.i_addr = '0;
    bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus.l2_rdata = '0; bus.l2_resp = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] a5, w1;
    int hc, pc, dc, ig, lat, r;
    a5 = {32{8'hA5}};
    w1 = {8{32'h1234_5678}};
    clear_in();
    model_reset();

    // reset state
    #12;
    chk("rst busy", bus.busy, 0);
    chk("rst l2_read", bus.l2_read, 0);
    chk("rst l2_write", bus.l2_write, 0);
    chk("rst l2_addr", bus.l2_addr, 0);
    chk("rst i_rdata", bus.i_rdata, 0);
    chk("rst d_resp", bus.d_resp, 0);
    rst_n = 1;
    @(posedge clk);
    model_update();
    #1;

    // single I read, response in 4th serve cycle
    bus.i_read = 1; bus.i_addr = 32'h0000_1000;
    step();
    hc = 0; pc = 0;
    for (int c = 0; c < 4; c++) begin
      bus.l2_resp = (c == 3);
      bus.l2_rdata = (c == 3) ? a5 : rnd_line();
      #1;
      hc += int'(bus.l2_read);
      pc += int'(bus.i_resp);
      if (c == 3) begin
        chk("single i_rdata", bus.i_rdata, a5);
        chk("single d_resp", bus.d_resp, 0);
      end
      step();
    end
    bus.i_read = 0; bus.l2_resp = 0;
    #1;
    pc += int'(bus.i_resp);
    chk("single gap l2_read", bus.l2_read, 0);
    chk("single read cycles", hc, 4);
    chk("single resp pulses", pc, 1);
    step(); step();

    // simultaneous I read and D write: D first
    bus.i_read = 1; bus.i_addr = 32'h1000;
    bus.d_write = 1; bus.d_addr = 32'h2000; bus.d_wdata = w1;
    step();
    #1;
    chk("sim d l2_write", bus.l2_write, 1);
    chk("sim d l2_addr", bus.l2_addr, 32'h2000);
    bus.l2_resp = 1;
    step();
    bus.d_write = 0; bus.l2_resp = 0;
    #1;
    chk("sim gap strobes", {bus.l2_read, bus.l2_write}, 0);
    chk("sim gap busy", bus.busy, 1);
    step();
    step();
    #1;
    chk("sim i l2_read", bus.l2_read, 1);
    chk("sim i l2_addr", bus.l2_addr, 32'h1000);
    bus.l2_resp = 1;
    step();
    bus.i_read = 0; bus.l2_resp = 0;
    step(); step();

    // starvation guard
    bus.i_read = 1; bus.i_addr = 32'h1000;
    bus.d_read = 1; bus.d_addr = 32'h3000;
    dc = 0; ig = 0;
    for (int c = 0; c < 60 && ig == 0; c++) begin
      #1;
      if (bus.l2_read) begin
        if (bus.l2_addr == 32'h3000) dc++;
        else ig = 1;
      end
      bus.l2_resp = bus.l2_read;
      step();
    end
    bus.i_read = 0; bus.d_read = 0; bus.l2_resp = 0;
    step(); step();
    chk("starve d grants", dc, 4);
    chk("starve i granted", ig, 1);
    chk("starve streak", dut.streak, 0);

    // latched address/data stay stable during SERVE_D
    bus.d_write = 1; bus.d_addr = 32'h4000; bus.d_wdata = w1;
    step();
    bus.d_addr = 32'h5000; bus.d_wdata = ~w1;
    #1;
    chk("stable l2_addr", bus.l2_addr, 32'h4000);
    chk("stable l2_wdata", bus.l2_wdata, w1);
    step();
    bus.l2_resp = 1;
    #1;
    chk("stable d_resp", bus.d_resp, 1);
    chk("stable l2_addr2", bus.l2_addr, 32'h4000);
    step();
    bus.d_write = 0; bus.l2_resp = 0;
    step(); step();

    // dropped request still completes
    bus.d_read = 1; bus.d_addr = 32'h6000;
    step();
    step();
    bus.d_read = 0;
    #1;
    chk("drop l2_read", bus.l2_read, 1);
    step();
    bus.l2_resp = 1;
    #1;
    chk("drop d_resp", bus.d_resp, 1);
    step();
    bus.l2_resp = 0;
    #1;
    chk("drop gap", {bus.busy, bus.l2_read}, 2'b10);
    step();
    chk("drop idle", bus.busy, 0);
    bus.i_read = 1; bus.i_addr = 32'h7000;
    step();
    #1;
    chk("drop next i", bus.l2_addr, 32'h7000);
    bus.l2_resp = 1;
    step();
    bus.i_read = 0; bus.l2_resp = 0;
    step(); step();

    // asynchronous reset in SERVE_D with l2_write high
    bus.d_write = 1; bus.d_addr = 32'h8000;
    step();
    #1;
    chk("arst pre l2_write", bus.l2_write, 1);
    bus.l2_resp = 1;
    #1;
    rst_n = 0;
    #1;
    chk("arst l2_write", bus.l2_write, 0);
    chk("arst d_resp", bus.d_resp, 0);
    chk("arst busy", bus.busy, 0);
    clear_in();
    model_reset();
    #2;
    rst_n = 1;
    @(posedge clk);
    model_update();
    #1;
    step();
    chk("arst idle", bus.busy, 0);

    // randomized traffic
    lat = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.i_read) begin
        if (e_iresp || $urandom_range(63) == 0) bus.i_read = 0;
      end else if ($urandom_range(2) == 0) begin
        bus.i_read = 1; bus.i_addr = $urandom;
      end
      if (bus.d_read | bus.d_write) begin
        if (e_dresp || $urandom_range(63) == 0) begin
          bus.d_read = 0; bus.d_write = 0;
        end else if ($urandom_range(7) == 0) begin
          bus.d_addr = $urandom; bus.d_wdata = rnd_line();
        end
      end else if ($urandom_range(1) == 0) begin
        r = $urandom_range(15);
        bus.d_read = (r < 7) || (r == 15);
        bus.d_write = (r >= 7);
        bus.d_addr = $urandom;
        bus.d_wdata = rnd_line();
      end
      bus.l2_rdata = rnd_line();
      if (m_cur != 0) begin
        bus.l2_resp = (lat == 0);
        lat = (lat == 0) ? $urandom_range(4) : lat - 1;
      end else begin
        bus.l2_resp = ($urandom_range(7) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
